// File: rtl/fb_arbiter_pkg.sv
// Shared types for the framebuffer arbiter: FSM state, read-owner tag and default sizing.
package fb_arbiter_pkg;
    localparam int AW_DEF     = 16;
    localparam int RD_LAT_DEF = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    typedef enum logic {
        OWN_DISP = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    typedef struct packed {
        logic   vld;
        owner_t owner;
    } tag_t;
endpackage

// File: rtl/fb_arbiter_rd_tag_pipe.sv
// Read-return tag delay line: tracks which requester owns each outstanding read.
// Latency: exactly RD_LAT cycles, matching the registered-output memory.
// Backpressure: none; shifts every cycle, cleared asynchronously by reset.
module rd_tag_pipe
    import fb_arbiter_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  tag_t i_tag,
    output tag_t o_tag
);
    tag_t pipe [RD_LAT];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= i_tag;
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign o_tag = pipe[RD_LAT-1];
endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: display > fill > host, one access per cycle.
// Latency: memory command is combinational; read returns RD_LAT cycles after issue.
// Backpressure: display never stalls; fill yields to display; host waits on o_host_ready.
module fb_arbiter
    import fb_arbiter_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_disp_req,
    input  logic [AW-1:0] i_disp_addr,
    output logic          o_disp_valid,
    output logic          o_disp_data,
    input  logic          i_host_valid,
    input  logic          i_host_we,
    input  logic [AW-1:0] i_host_addr,
    input  logic          i_host_wdata,
    output logic          o_host_ready,
    output logic          o_host_rvalid,
    output logic          o_host_rdata,
    input  logic          i_clr_start,
    input  logic          i_clr_value,
    output logic          o_clr_busy,
    output logic          o_mem_ce,
    output logic          o_mem_wre,
    output logic [AW-1:0] o_mem_ad,
    output logic          o_mem_din,
    input  logic          i_mem_dout
);
    state_t        state;
    logic [AW-1:0] fill_cnt;
    logic          fill_val;
    logic          disp_acc;
    logic          fill_acc;
    logic          host_acc;
    tag_t          tag_in;
    tag_t          tag_out;

    // Display path is combinational, so reset must gate it explicitly.
    assign disp_acc     = i_rst_n & i_disp_req;
    assign fill_acc     = (state == ST_CLEAR) & ~i_disp_req;
    assign o_host_ready = i_rst_n & i_host_valid & ~i_disp_req & (state == ST_IDLE) & ~i_clr_start;
    assign host_acc     = o_host_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            fill_cnt   <= '0;
            fill_val   <= 1'b0;
            o_clr_busy <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_clr_start) begin
                        state      <= ST_CLEAR;
                        fill_cnt   <= '0;
                        fill_val   <= i_clr_value;
                        o_clr_busy <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (!i_disp_req) begin
                        fill_cnt <= fill_cnt + 1'b1;
                        if (fill_cnt == {AW{1'b1}}) begin
                            state      <= ST_IDLE;
                            o_clr_busy <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_mem_ce  = 1'b0;
        o_mem_wre = 1'b0;
        o_mem_ad  = '0;
        o_mem_din = 1'b0;
        if (disp_acc) begin
            o_mem_ce = 1'b1;
            o_mem_ad = i_disp_addr;
        end else if (fill_acc) begin
            o_mem_ce  = 1'b1;
            o_mem_wre = 1'b1;
            o_mem_ad  = fill_cnt;
            o_mem_din = fill_val;
        end else if (host_acc) begin
            o_mem_ce  = 1'b1;
            o_mem_wre = i_host_we;
            o_mem_ad  = i_host_addr;
            o_mem_din = i_host_we & i_host_wdata;
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.vld   = disp_acc | (host_acc & ~i_host_we);
        tag_in.owner = disp_acc ? OWN_DISP : OWN_HOST;
    end

    rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_tag  (tag_in),
        .o_tag  (tag_out)
    );

    assign o_disp_valid  = tag_out.vld & (tag_out.owner == OWN_DISP);
    assign o_host_rvalid = tag_out.vld & (tag_out.owner == OWN_HOST);
    assign o_disp_data   = o_disp_valid & i_mem_dout;
    assign o_host_rdata  = o_host_rvalid & i_mem_dout;
endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: small-AW instance for fill/host/routing, AW=16 instance for the 0x1234 fetch.
module tb_fb_arbiter;
    localparam int AW     = 4;
    localparam int RD_LAT = 2;
    localparam int N      = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          host_valid = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic          host_wdata = 1'b0;
    logic          clr_start = 1'b0;
    logic          clr_value = 1'b0;
    logic          disp_valid, disp_data, host_ready, host_rvalid, host_rdata;
    logic          clr_busy, mem_ce, mem_wre, mem_din, mem_dout;
    logic [AW-1:0] mem_ad;

    fb_arbiter #(.AW(AW), .RD_LAT(RD_LAT)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_disp_req(disp_req), .i_disp_addr(disp_addr),
        .o_disp_valid(disp_valid), .o_disp_data(disp_data),
        .i_host_valid(host_valid), .i_host_we(host_we),
        .i_host_addr(host_addr), .i_host_wdata(host_wdata),
        .o_host_ready(host_ready), .o_host_rvalid(host_rvalid), .o_host_rdata(host_rdata),
        .i_clr_start(clr_start), .i_clr_value(clr_value), .o_clr_busy(clr_busy),
        .o_mem_ce(mem_ce), .o_mem_wre(mem_wre), .o_mem_ad(mem_ad), .o_mem_din(mem_din),
        .i_mem_dout(mem_dout)
    );

    // Registered-output memory, RD_LAT cycles from command to data.
    logic mem [N] = '{default: 1'b0};
    logic rd_pipe [RD_LAT] = '{default: 1'b0};
    always @(posedge clk) begin
        if (mem_ce && mem_wre) mem[mem_ad] <= mem_din;
        if (mem_ce && !mem_wre) rd_pipe[0] <= mem[mem_ad];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_dout = rd_pipe[RD_LAT-1];

    // Wide instance: memory holds 1 only at 0x1234.
    logic        w_disp_req = 1'b0;
    logic [15:0] w_disp_addr = '0;
    logic        w_zero = 1'b0;
    logic [15:0] w_zero16 = '0;
    logic        w_disp_valid, w_disp_data, w_host_ready, w_host_rvalid, w_host_rdata;
    logic        w_clr_busy, w_mem_ce, w_mem_wre, w_mem_din, w_mem_dout;
    logic [15:0] w_mem_ad;
    logic        w_rd0 = 1'b0, w_rd1 = 1'b0;

    fb_arbiter #(.AW(16), .RD_LAT(2)) u_dut16 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_disp_req(w_disp_req), .i_disp_addr(w_disp_addr),
        .o_disp_valid(w_disp_valid), .o_disp_data(w_disp_data),
        .i_host_valid(w_zero), .i_host_we(w_zero),
        .i_host_addr(w_zero16), .i_host_wdata(w_zero),
        .o_host_ready(w_host_ready), .o_host_rvalid(w_host_rvalid), .o_host_rdata(w_host_rdata),
        .i_clr_start(w_zero), .i_clr_value(w_zero), .o_clr_busy(w_clr_busy),
        .o_mem_ce(w_mem_ce), .o_mem_wre(w_mem_wre), .o_mem_ad(w_mem_ad), .o_mem_din(w_mem_din),
        .i_mem_dout(w_mem_dout)
    );
    always @(posedge clk) begin
        if (w_mem_ce && !w_mem_wre) w_rd0 <= (w_mem_ad == 16'h1234);
        w_rd1 <= w_rd0;
    end
    assign w_mem_dout = w_rd1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Reference model: memory image plus expected returns keyed by due cycle.
    logic ref_mem [N] = '{default: 1'b0};
    logic ed_v [64], ed_d [64], eh_v [64], eh_d [64];

    task automatic clear_ring();
        for (int i = 0; i < 64; i++) begin
            ed_v[i] = 1'b0; ed_d[i] = 1'b0; eh_v[i] = 1'b0; eh_d[i] = 1'b0;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        disp_req = 1'b1; disp_addr = 4'h5; host_valid = 1'b1; host_we = 1'b1;
        host_wdata = 1'b1; clr_start = 1'b1; clr_value = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({disp_valid, host_rvalid, host_ready, clr_busy, mem_wre, mem_ce, mem_din} !== 7'b0) begin
                bad++;
                $display("FAIL reset_outputs: got %b want 0000000", {disp_valid, host_rvalid, host_ready, clr_busy, mem_wre, mem_ce, mem_din});
            end
            total++;
            if (mem_ad !== '0) begin bad++; $display("FAIL reset_mem_ad: got %h want 0", mem_ad); end
        end
        next_cycle();
        rst_n = 1'b1; host_valid = 1'b0; host_we = 1'b0; clr_start = 1'b0; clr_value = 1'b0;
        @(negedge clk);
        total++;
        if (mem_ce !== 1'b1 || mem_wre !== 1'b0 || mem_ad !== 4'h5) begin
            bad++; $display("FAIL first_req: ce=%b wre=%b ad=%h want 1 0 5", mem_ce, mem_wre, mem_ad);
        end
        total++;
        if (clr_busy !== 1'b0) begin bad++; $display("FAIL reset_clr_ignored: busy=%b want 0", clr_busy); end
        next_cycle();
        disp_req = 1'b0;
        @(negedge clk);
        total++;
        if (disp_valid !== 1'b0) begin bad++; $display("FAIL first_req_early: valid=%b want 0", disp_valid); end
        next_cycle();
        @(negedge clk);
        total++;
        if (disp_valid !== 1'b1 || disp_data !== ref_mem[5]) begin
            bad++; $display("FAIL first_req_ret: valid=%b data=%b want 1 %b", disp_valid, disp_data, ref_mem[5]);
        end
        next_cycle();
    endtask

    task automatic test_disp_wide();
        w_disp_req = 1'b1; w_disp_addr = 16'h1234;
        @(negedge clk);
        total++;
        if (w_mem_ce !== 1'b1 || w_mem_wre !== 1'b0 || w_mem_ad !== 16'h1234) begin
            bad++; $display("FAIL disp_addr16: ce=%b wre=%b ad=%h want 1 0 1234", w_mem_ce, w_mem_wre, w_mem_ad);
        end
        next_cycle();
        w_disp_req = 1'b0; w_disp_addr = 16'h0000;
        @(negedge clk);
        total++;
        if (w_disp_valid !== 1'b0) begin bad++; $display("FAIL disp16_early: valid=%b want 0", w_disp_valid); end
        next_cycle();
        @(negedge clk);
        total++;
        if (w_disp_valid !== 1'b1 || w_disp_data !== 1'b1 || w_host_rvalid !== 1'b0) begin
            bad++; $display("FAIL disp16_ret: valid=%b data=%b hrv=%b want 1 1 0", w_disp_valid, w_disp_data, w_host_rvalid);
        end
        next_cycle();
    endtask

    task automatic test_host_stall();
        host_valid = 1'b1; host_we = 1'b1; host_addr = 4'hF; host_wdata = 1'b1;
        for (int i = 0; i < 6; i++) begin
            disp_req = (i < 5); disp_addr = 4'(i);
            @(negedge clk);
            total++;
            if (host_ready !== (i == 5)) begin
                bad++; $display("FAIL stall_ready[%0d]: got %b want %b", i, host_ready, (i == 5));
            end
            if (i == 5) begin
                total++;
                if (mem_ce !== 1'b1 || mem_wre !== 1'b1 || mem_ad !== 4'hF || mem_din !== 1'b1) begin
                    bad++; $display("FAIL stall_write: ce=%b wre=%b ad=%h din=%b want 1 1 f 1", mem_ce, mem_wre, mem_ad, mem_din);
                end
            end
            next_cycle();
        end
        ref_mem[15] = 1'b1;
        disp_req = 1'b0; host_we = 1'b0;
        @(negedge clk);
        total++;
        if (host_ready !== 1'b1 || mem_wre !== 1'b0) begin
            bad++; $display("FAIL stall_read_acc: ready=%b wre=%b want 1 0", host_ready, mem_wre);
        end
        next_cycle();
        host_valid = 1'b0;
        @(negedge clk);
        total++;
        if (host_rvalid !== 1'b0) begin bad++; $display("FAIL stall_read_early: rvalid=%b want 0", host_rvalid); end
        next_cycle();
        @(negedge clk);
        total++;
        if (host_rvalid !== 1'b1 || host_rdata !== 1'b1) begin
            bad++; $display("FAIL stall_read_ret: rvalid=%b rdata=%b want 1 1", host_rvalid, host_rdata);
        end
        next_cycle();
    endtask

    task automatic test_interleave_random();
        logic          dr, hv, we, wd;
        logic [AW-1:0] da, ha;
        logic [5:0]    s;
        clear_ring();
        for (int i = 0; i < 240; i++) begin
            if (i < 20) begin
                dr = (i % 2 == 0); hv = !dr; we = 1'b0;
            end else begin
                dr = ($urandom_range(0, 2) == 0); hv = 1'($urandom); we = 1'($urandom);
            end
            if (i >= 240 - RD_LAT) begin dr = 1'b0; hv = 1'b0; end
            da = 4'($urandom_range(0, N-1)); ha = 4'($urandom_range(0, N-1)); wd = 1'($urandom);
            disp_req = dr; disp_addr = da; host_valid = hv; host_we = we; host_addr = ha; host_wdata = wd;
            @(negedge clk);
            s = 6'(cyc);
            total++;
            if (host_ready !== (hv && !dr)) begin
                bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, host_ready, (hv && !dr));
            end
            total++;
            if (mem_ce !== (dr || hv) || (dr && (mem_ad !== da || mem_wre !== 1'b0))
                || (!dr && hv && (mem_ad !== ha || mem_wre !== we || (we && mem_din !== wd)))) begin
                bad++; $display("FAIL rnd_mem[%0d]: ce=%b wre=%b ad=%h din=%b", i, mem_ce, mem_wre, mem_ad, mem_din);
            end
            total++;
            if (disp_valid !== ed_v[s] || (ed_v[s] && disp_data !== ed_d[s])
                || host_rvalid !== eh_v[s] || (eh_v[s] && host_rdata !== eh_d[s])) begin
                bad++;
                $display("FAIL rnd_ret[%0d]: dv=%b dd=%b hv=%b hd=%b want %b %b %b %b", i, disp_valid, disp_data,
                         host_rvalid, host_rdata, ed_v[s], ed_d[s], eh_v[s], eh_d[s]);
            end
            total++;
            if (disp_valid && host_rvalid) begin bad++; $display("FAIL rnd_both[%0d]: dv=1 hv=1 want one", i); end
            ed_v[s] = 1'b0; eh_v[s] = 1'b0;
            s = 6'(cyc + RD_LAT);
            if (dr) begin
                ed_v[s] = 1'b1; ed_d[s] = ref_mem[da];
            end else if (hv && !we) begin
                eh_v[s] = 1'b1; eh_d[s] = ref_mem[ha];
            end else if (hv && we) begin
                ref_mem[ha] = wd;
            end
            next_cycle();
        end
    endtask

    task automatic test_fill_vs_host();
        int            writes = 0, busy_cycles = 0, k = 0, cnt = 0;
        logic [N-1:0]  covered = '0;
        logic [5:0]    s;
        logic          done = 1'b0;
        clear_ring();
        disp_req = 1'b0; host_valid = 1'b1; host_we = 1'b0; host_addr = 4'h3;
        @(negedge clk);
        total++;
        if (host_ready !== 1'b1) begin bad++; $display("FAIL fill_pre_read: ready=%b want 1", host_ready); end
        s = 6'(cyc + RD_LAT); eh_v[s] = 1'b1; eh_d[s] = ref_mem[3];
        next_cycle();
        host_we = 1'b1; host_addr = 4'h9; host_wdata = 1'b0; clr_start = 1'b1; clr_value = 1'b1;
        @(negedge clk);
        total++;
        if (host_ready !== 1'b0 || mem_ce !== 1'b0) begin
            bad++; $display("FAIL clr_vs_host: ready=%b ce=%b want 0 0", host_ready, mem_ce);
        end
        next_cycle();
        clr_start = 1'b0;
        while (!done && k < 40) begin
            disp_req = (k == 2 || k == 7 || k == 11); disp_addr = 4'(k);
            clr_start = (k == 5); clr_value = 1'b0;
            @(negedge clk);
            s = 6'(cyc);
            total++;
            if (disp_valid !== ed_v[s] || (ed_v[s] && disp_data !== ed_d[s])
                || host_rvalid !== eh_v[s] || (eh_v[s] && host_rdata !== eh_d[s])) begin
                bad++;
                $display("FAIL fill_ret[%0d]: dv=%b dd=%b hv=%b hd=%b want %b %b %b %b", k, disp_valid, disp_data,
                         host_rvalid, host_rdata, ed_v[s], ed_d[s], eh_v[s], eh_d[s]);
            end
            ed_v[s] = 1'b0; eh_v[s] = 1'b0;
            if (mem_ce && mem_wre) begin writes++; covered[mem_ad] = 1'b1; end
            if (clr_busy) begin
                busy_cycles++;
                total++;
                if (host_ready !== 1'b0) begin bad++; $display("FAIL fill_ready[%0d]: got %b want 0", k, host_ready); end
                total++;
                if (disp_req) begin
                    if (mem_ce !== 1'b1 || mem_wre !== 1'b0 || mem_ad !== disp_addr) begin
                        bad++; $display("FAIL fill_disp[%0d]: ce=%b wre=%b ad=%h want 1 0 %h", k, mem_ce, mem_wre, mem_ad, disp_addr);
                    end
                    s = 6'(cyc + RD_LAT); ed_v[s] = 1'b1; ed_d[s] = ref_mem[disp_addr];
                end else begin
                    if (mem_ce !== 1'b1 || mem_wre !== 1'b1 || mem_ad !== 4'(cnt) || mem_din !== 1'b1) begin
                        bad++; $display("FAIL fill_wr[%0d]: ce=%b wre=%b ad=%h din=%b want 1 1 %h 1", k, mem_ce, mem_wre, mem_ad, mem_din, 4'(cnt));
                    end
                    ref_mem[4'(cnt)] = 1'b1;
                    cnt++;
                end
            end else begin
                done = 1'b1;
                total++;
                if (host_ready !== 1'b1 || mem_wre !== 1'b1 || mem_ad !== 4'h9 || mem_din !== 1'b0) begin
                    bad++; $display("FAIL post_fill_write: ready=%b wre=%b ad=%h din=%b want 1 1 9 0", host_ready, mem_wre, mem_ad, mem_din);
                end
                ref_mem[9] = 1'b0;
            end
            next_cycle();
            k++;
        end
        host_valid = 1'b0; disp_req = 1'b0; clr_start = 1'b0;
        total++;
        if (!done) begin bad++; $display("FAIL fill_timeout: busy still %b after %0d cycles", clr_busy, k); end
        total++;
        if (writes !== 16 + 1) begin bad++; $display("FAIL fill_writes: got %0d want 17 (16 fill + 1 host)", writes); end
        total++;
        if (covered !== {N{1'b1}}) begin bad++; $display("FAIL fill_cover: got %h want ffff", covered); end
        total++;
        if (busy_cycles !== 19) begin bad++; $display("FAIL fill_busy_len: got %0d want 19", busy_cycles); end
    endtask

    task automatic test_reset_mid_fill();
        logic found = 1'b0;
        host_valid = 1'b1; host_we = 1'b1; host_wdata = 1'b1;
        for (int a = 0; a < N; a++) begin
            host_addr = 4'(a);
            next_cycle();
            ref_mem[a] = 1'b1;
        end
        host_valid = 1'b0; clr_start = 1'b1; clr_value = 1'b0;
        next_cycle();
        clr_start = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (mem_ce && mem_wre && mem_ad == 4'h7) begin
                found = 1'b1;
                rst_n = 1'b0;
                #1;
                total++;
                if ({disp_valid, host_rvalid, host_ready, clr_busy, mem_wre, mem_ce, mem_din} !== 7'b0 || mem_ad !== '0) begin
                    bad++; $display("FAIL mid_fill_reset: outs=%b ad=%h want all 0",
                                    {disp_valid, host_rvalid, host_ready, clr_busy, mem_wre, mem_ce, mem_din}, mem_ad);
                end
            end
            next_cycle();
        end
        total++;
        if (!found) begin bad++; $display("FAIL mid_fill_find: address 7 write not seen, found=%b want 1", found); end
        rst_n = 1'b1;
        for (int a = 0; a < 7; a++) ref_mem[a] = 1'b0;
        for (int i = 0; i < N + RD_LAT; i++) begin
            host_valid = (i < N); host_we = 1'b0; host_addr = 4'(i);
            @(negedge clk);
            if (i == 0) begin
                total++;
                if (clr_busy !== 1'b0 || host_ready !== 1'b1) begin
                    bad++; $display("FAIL mid_fill_idle: busy=%b ready=%b want 0 1", clr_busy, host_ready);
                end
            end
            if (i >= RD_LAT) begin
                total++;
                if (host_rvalid !== 1'b1 || host_rdata !== ref_mem[i-RD_LAT]) begin
                    bad++; $display("FAIL mid_fill_read[%0d]: rvalid=%b rdata=%b want 1 %b", i-RD_LAT, host_rvalid, host_rdata, ref_mem[i-RD_LAT]);
                end
            end
            next_cycle();
        end
        host_valid = 1'b0;
    endtask

    task automatic test_reset_inflight();
        host_valid = 1'b1; host_we = 1'b0; host_addr = 4'h0;
        next_cycle();
        host_valid = 1'b0; disp_req = 1'b1; disp_addr = 4'h1;
        next_cycle();
        disp_req = 1'b0; rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (disp_valid !== 1'b0 || host_rvalid !== 1'b0) begin
                bad++; $display("FAIL inflight_discard[%0d]: dv=%b hv=%b want 0 0", i, disp_valid, host_rvalid);
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_disp_wide();
        test_host_stall();
        test_interleave_random();
        test_fill_vs_host();
        test_reset_mid_fill();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter AW, default 16: framebuffer address width.
REQ-002 Parameter RD_LAT, default 2: memory read latency in cycles (registered-output BSRAM).
REQ-003 Port i_clk  in  1: pixel clock, the same clock that drives the sync generators.
REQ-004 Port i_rst_n  in  1: reset, asynchronous, active-low.
REQ-005 Port i_disp_req  in  1: display fetch request for the current cycle.
REQ-006 Port i_disp_addr  in  AW: display fetch address.
REQ-007 Port o_disp_valid / o_disp_data  out  1/1: display read return.
REQ-008 Port i_host_valid  in  1: host request valid.
REQ-009 Port i_host_we  in  1: host request type, 1=write, 0=read.
REQ-010 Port i_host_addr / i_host_wdata  in  AW/1: host address and write data.
REQ-011 Port o_host_ready  out  1: host request accepted this cycle.
REQ-012 Port o_host_rvalid / o_host_rdata  out  1/1: host read return.
REQ-013 Port i_clr_start / i_clr_value  in  1/1: start a framebuffer fill, and the fill value.
REQ-014 Port o_clr_busy  out  1: fill in progress.
REQ-015 Port o_mem_ce / o_mem_wre / o_mem_ad / o_mem_din  out  1/1/AW/1: memory port.
REQ-016 Port i_mem_dout  in  1: memory read data.

Function
REQ-017 One memory access per cycle; priority order: display > fill > host.
REQ-018 The display is never stalled: i_disp_req=1 drives o_mem_ce=1, o_mem_wre=0, o_mem_ad=i_disp_addr in the same cycle, combinationally.
REQ-019 The display return arrives exactly RD_LAT cycles after the request: o_disp_valid=1 and o_disp_data=i_mem_dout.
REQ-020 A tag pipeline RD_LAT deep (valid, owner) routes i_mem_dout to either the display return or the host return; only one return asserts per cycle.
REQ-021 o_host_ready=1 only when i_host_valid=1, i_disp_req=0, and the FSM is IDLE.
REQ-022 A host transaction happens on the cycle with i_host_valid & o_host_ready.
REQ-023 An accepted host write drives o_mem_wre=1 and o_mem_din=i_host_wdata, and produces no return.
REQ-024 An accepted host read produces o_host_rvalid=1 exactly RD_LAT cycles later.
REQ-025 The host holds its valid and request fields stable until ready; the block does not latch host requests.
REQ-026 FSM states are IDLE and CLEAR.
REQ-027 IDLE -> CLEAR on i_clr_start=1: latch i_clr_value, set the fill counter to 0, set o_clr_busy=1 in the following cycle.
REQ-028 In CLEAR, each cycle with i_disp_req=0 writes the latched value at the counter address, then increments the counter.
REQ-029 A cycle in CLEAR with i_disp_req=1 leaves the counter unchanged.
REQ-030 CLEAR -> IDLE after writing address 2^AW-1; o_clr_busy drops the cycle after that write.
REQ-031 Simultaneous i_clr_start and a host request in IDLE: the fill wins and o_host_ready=0.
REQ-032 i_clr_start is ignored while the FSM is in CLEAR.
REQ-033 In-flight host reads still return while the FSM is in CLEAR.
REQ-034 Idle cycles (no display, fill or host access) drive o_mem_ce=0 and o_mem_wre=0.

Reset
REQ-035 While i_rst_n=0: FSM=IDLE, fill counter=0, tag pipeline cleared.
REQ-036 While i_rst_n=0: o_disp_valid, o_host_rvalid, o_host_ready, o_clr_busy, o_mem_wre and o_mem_ce are 0; o_mem_ad and o_mem_din are 0.
REQ-037 Reset during CLEAR abandons the fill; no resume after release.
REQ-038 Reset discards in-flight reads; no returns follow the release.
REQ-039 The first request is honoured on the first clock edge after reset release.

Structure
REQ-040 Shared package holds the FSM state typedef (IDLE, CLEAR), the owner tag encoding (DISP, HOST), and the AW/RD_LAT defaults.
REQ-041 One sub-module, rd_tag_pipe: parameterised RD_LAT-deep shift register of {valid, owner} with asynchronous reset.

Verification
REQ-042 Display request at address 0x1234 with memory model data 1 -> o_mem_ad=0x1234 the same cycle; o_disp_valid=1 and data=1 exactly 2 cycles later.
REQ-043 Host write (addr 0x00FF, data 1) held while i_disp_req=1 for 5 cycles -> ready=0 for those 5 cycles; write issued in the 6th cycle; a later host read of 0x00FF returns 1 after 2 cycles.
REQ-044 Interleaved display and host reads on alternate cycles -> every return is routed to the correct owner with the correct data; o_disp_valid and o_host_rvalid are never both 1.
REQ-045 Fill with value 1, AW=4, i_disp_req asserted on 3 cycles -> exactly 16 writes covering 0..15; busy lasts 19 cycles; host ready=0 throughout.
REQ-046 Reset asserted at counter=7 during CLEAR -> all outputs 0 immediately; IDLE after release; a host read returns the pre-fill data for addresses >= 7.
REQ-047 i_clr_start in the same cycle as a host write -> fill starts; host ready=0; host write accepted only after busy drops.
